// File: rtl/block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : block_packer
//  Description : Byte-stream to big-endian block packer with ISO/IEC 7816-4
//                bit padding (0x80 then zeros). A message whose length is an
//                exact multiple of the block size is followed by a full pad
//                block, so every message ends in exactly one padded block.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_packer #(
    parameter int IWIDTH = 64,
    parameter int CWIDTH = $clog2(IWIDTH/8) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [IWIDTH-1:0] out_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_padded,
    output logic              out_last,
    output logic [CWIDTH-1:0] out_nbytes
);

    localparam int NBYTES = IWIDTH / 8;
    localparam int CNTW   = $clog2(NBYTES);

    localparam logic [CNTW-1:0]   C_CNT_LAST  = CNTW'(NBYTES - 1);
    localparam logic [CWIDTH-1:0] C_NB_FULL   = CWIDTH'(NBYTES);
    localparam logic [IWIDTH-1:0] C_PAD_BLOCK = {8'h80, {(IWIDTH-8){1'b0}}};

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PADBLK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                pad_pending_q, pad_pending_d;
    logic [IWIDTH-1:0]   block_q, block_d;
    logic                padded_q, padded_d;
    logic                last_q, last_d;
    logic [CWIDTH-1:0]   nbytes_q, nbytes_d;

    // Block image after writing the current byte; one extra bit so that the
    // lane after the final lane never matches.
    logic [CNTW:0]       cnt_inc;
    logic [IWIDTH-1:0]   fill_block;

    assign cnt_inc = {1'b0, cnt_q} + {{CNTW{1'b0}}, 1'b1};

    // Merge the incoming byte into lane cnt; lanes above it are cleared so no
    // stale data survives, and the next lane carries 0x80 on the last byte.
    always_comb begin
        fill_block = block_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (CNTW'(i) == cnt_q) begin
                fill_block[IWIDTH-1-8*i -: 8] = in_data;
            end else if ((CNTW+1)'(i) == cnt_inc) begin
                fill_block[IWIDTH-1-8*i -: 8] = in_last ? 8'h80 : 8'h00;
            end else if (CNTW'(i) > cnt_q) begin
                fill_block[IWIDTH-1-8*i -: 8] = 8'h00;
            end
        end
    end

    // Next-state and next-output decode for the FILL/HOLD/PADBLK sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        block_d       = block_q;
        padded_d      = padded_q;
        last_d        = last_q;
        nbytes_d      = nbytes_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    block_d = fill_block;
                    if (cnt_q == C_CNT_LAST) begin
                        // Full block; a last byte here defers padding to a
                        // dedicated pad block.
                        state_d       = ST_HOLD;
                        padded_d      = 1'b0;
                        last_d        = 1'b0;
                        nbytes_d      = C_NB_FULL;
                        pad_pending_d = in_last;
                        cnt_d         = '0;
                    end else if (in_last) begin
                        state_d  = ST_HOLD;
                        padded_d = 1'b1;
                        last_d   = 1'b1;
                        nbytes_d = CWIDTH'(cnt_q) + CWIDTH'(1);
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (pad_pending_q) begin
                        state_d       = ST_PADBLK;
                        pad_pending_d = 1'b0;
                        block_d       = C_PAD_BLOCK;
                        padded_d      = 1'b1;
                        last_d        = 1'b1;
                        nbytes_d      = '0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_PADBLK: begin
                if (out_ready) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and output registers; reset discards any partial block or pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            block_q       <= '0;
            padded_q      <= 1'b0;
            last_q        <= 1'b0;
            nbytes_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            block_q       <= block_d;
            padded_q      <= padded_d;
            last_q        <= last_d;
            nbytes_q      <= nbytes_d;
        end
    end

    // Handshakes decode from registered state only (no out_ready -> in_ready path).
    assign in_ready   = (state_q == ST_FILL);
    assign out_valid  = (state_q != ST_FILL);
    assign out_block  = block_q;
    assign out_padded = padded_q;
    assign out_last   = last_q;
    assign out_nbytes = nbytes_q;

endmodule
`default_nettype wire

// File: doc/block_packer.md
# block_packer

Byte-stream to cipher-block packer that sits directly upstream of `padding2`. It accepts a message one byte at a time over a valid/ready handshake and assembles big-endian `IWIDTH`-bit blocks. It applies ISO/IEC 7816-4 bit padding to the final block: `0x80`, then zero bytes. It also appends a full pad block when the message length is an exact multiple of the block size, so every message ends with exactly one padded block for the cipher core.

## Interface
- `IWIDTH`, default 64: output block width in bits. Must be a multiple of 8 and at least 16. `NBYTES = IWIDTH/8`.
- `CWIDTH`, default `$clog2(IWIDTH/8)+1`: width of `out_nbytes`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  qualifies the final byte of the message; meaningful only while `in_valid` is high.
- `in_ready`  out  1  packer can accept a byte.
- `out_block`  out  IWIDTH  packed, padded block. The first byte occupies `[IWIDTH-1:IWIDTH-8]`.
- `out_valid`  out  1  `out_block` is valid.
- `out_ready`  in  1  downstream accepts the block.
- `out_padded`  out  1  block contains the `0x80` pad marker.
- `out_last`  out  1  block is the final block of the message.
- `out_nbytes`  out  CWIDTH  count of message (non-pad) bytes in the block, 0..NBYTES.

## Operation
- A transfer occurs on a rising edge where valid and ready are both high. This rule applies to both the input side and the output side.
- States:
  - FILL: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
  - PADBLK: `in_ready=0`, `out_valid=1`.
- Byte counter `cnt` runs 0..NBYTES-1. An accepted byte is written to byte lane `cnt` (MSB-first), and `cnt` then increments.
- Transitions from FILL on an accepted byte:
  - `cnt<NBYTES-1`, `in_last=0`: remain in FILL.
  - `cnt==NBYTES-1`, `in_last=0`: go to HOLD with `padded=0`, `last=0`, `nbytes=NBYTES`, `cnt←0`.
  - `cnt<NBYTES-1`, `in_last=1`: lane `cnt+1` becomes `0x80` and the remaining lanes become `0x00`. Go to HOLD with `padded=1`, `last=1`, `nbytes=cnt+1`, `cnt←0`.
  - `cnt==NBYTES-1`, `in_last=1`: go to HOLD with `padded=0`, `last=0`, `nbytes=NBYTES`, set `pad_pending`, `cnt←0`.
- Transitions from HOLD on an output transfer:
  - `pad_pending=1`: go to PADBLK and clear `pad_pending`.
  - otherwise: go to FILL.
- PADBLK outputs `out_block = {8'h80, {IWIDTH-8{1'b0}}}` with `padded=1`, `last=1`, `nbytes=0`. On an output transfer it goes to FILL.
- Lanes not yet written in FILL must be cleared before reuse. No data from a previous block may leak into a padded block.
- Zero-length messages are not supported, because `in_last` always accompanies a data byte.

## Timing
- Reset (`rst_n` low, takes effect asynchronously):
  - state = FILL, `cnt=0`, `pad_pending=0`.
  - `out_block=0`, `out_valid=0`, `out_padded=0`, `out_last=0`, `out_nbytes=0`.
  - `in_ready` reads 1, but no transfer is registered while `rst_n` is low.
- Latency: `out_valid` rises on the clock edge that accepts the block-completing byte, i.e. it is visible in the next cycle.
- `out_block`, `out_padded`, `out_last` and `out_nbytes` are registered. They must hold stable while `out_valid=1` and `out_ready=0`.
- `in_ready` is decoded from registered state only, with no combinational path from `out_ready`. As a consequence, at least one bubble cycle occurs per block.
- Throughput: NBYTES+1 cycles per block with `out_ready` held high. A pad block adds one further cycle.
- Reset asserted mid-fill or mid-hold discards the partial block and any pending pad. The next accepted byte starts a new block in lane 0.
- `in_data` and `in_last` are ignored whenever `in_ready=0`.

## Test plan
- **3-byte message.** Input: `01 02 03` with `last` on `03`, `out_ready=1`. Required: exactly one block `0x0102038000000000`, with `padded=1`, `last=1`, `nbytes=3`.
- **Block-aligned message.** Input: 8 bytes `01..08` with `last` on `08`. Required:
  - block `0x0102030405060708` with `padded=0`, `last=0`, `nbytes=8`,
  - then block `0x8000000000000000` with `padded=1`, `last=1`, `nbytes=0`.
- **11-byte message.** Input: `A0..AA`. Required:
  - block `0xA0A1A2A3A4A5A6A7` with `last=0`,
  - then block `0xA8A9AA8000000000` with `padded=1`, `last=1`, `nbytes=3`.
  - A second message that follows immediately must start cleanly in lane 0.
- **Backpressure.** Hold `out_ready=0` for 5 cycles during HOLD. Required: block and flags stable, `in_ready=0`, and input bytes offered during the stall are not consumed. The transfer completes on the first edge with `out_ready=1`.
- **Reset mid-fill.** Input: 4 bytes `FF`, then a `rst_n` pulse, then `01` with `last`. Required: block `0x0180000000000000` with `nbytes=1`. No `FF` may appear in any block.
- **Reset during PADBLK.** Required: `out_valid` falls asynchronously, and no pad block is emitted after `rst_n` is released.
